// File: rtl/and_pkg.sv
// Shared definitions for the 3-bit AND datapath.
// Holds the default word width and a popcount helper.
package and_pkg;

  localparam int WIDTH_DEF = 3;
  localparam int PC_W = $clog2(WIDTH_DEF + 1);

  function automatic logic [PC_W-1:0] popcount(
    input logic [WIDTH_DEF-1:0] w
  );
    popcount = '0;
    for (int i = 0; i < WIDTH_DEF; i++) begin
      popcount = popcount + PC_W'(w[i]);
    end
  endfunction

endpackage

// File: rtl/ones_counter.sv
// Saturating running total of set bits across accepted words.
// sat is sticky once the total reaches its ceiling.
module ones_counter
  import and_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] total,
  output logic             sat
);

  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [PC_W-1:0]  pc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] total_q, total_d;
  logic             sat_q, sat_d;

  assign pc  = popcount(word);
  assign sum = {1'b0, total_q} + (CNT_W + 1)'(pc);

  // Landing exactly on the ceiling counts as saturated too.
  always_comb begin
    total_d = total_q;
    sat_d   = sat_q;
    if (inc_en) begin
      if (sum >= MAX) begin
        total_d = MAX[CNT_W-1:0];
        sat_d   = 1'b1;
      end else begin
        total_d = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      sat_q   <= sat_d;
    end
  end

  assign total = total_q;
  assign sat   = sat_q;

endmodule

// File: rtl/and_result_buffer.sv
// Flop-based FIFO for AND results with a valid/ready handshake
// on both sides and a saturating ones counter on the input.
module and_result_buffer
  import and_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           ones_total,
  output logic                       ones_sat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign count = count_q;

  ones_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ones (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (push),
    .word   (in_data),
    .total  (ones_total),
    .sat    (ones_sat)
  );

endmodule
